// File: rtl/samus_motion_ctrl.sv
// samus_motion_ctrl
//   Per-frame player motion engine sitting between the NIOS keycode export and
//   sprite_mapper. It decodes two USB HID key bytes into left/right/jump intents
//   and, once per VGA frame, integrates horizontal position and jump/gravity
//   physics.
//
// Ports
//   clk        in   1   system clock (CLOCK_50)
//   reset      in   1   synchronous, active-high
//   vsync      in   1   VGA_VS, active low; falling edge marks a new frame
//   enable     in   1   1 = game running, 0 = motion frozen
//   keycode    in   16  two HID codes [7:0],[15:8]; 0x04=A left, 0x07=D right, 0x1A=W jump
//   samus_x    out  10  sprite x (top-left)
//   samus_y    out  10  sprite y (top-left)
//   direction  out  1   0 = facing right, 1 = facing left
//   walk       out  1   walk animation phase bit
//   jump       out  1   1 while airborne
//
// Build option
//   SAMUS_DOUBLE_JUMP_EN : when defined, one extra take-off is allowed while
//   airborne (re-armed W press); the allowance is restored on landing.
//
// The take-off frame already applies the first upward step, so the sprite
// leaves the floor on the same frame the jump is accepted.
module samus_motion_ctrl #(
  parameter int unsigned X_START   = 304,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 608,
  parameter int unsigned GROUND_Y  = 400,
  parameter int unsigned WALK_STEP = 2,
  parameter int unsigned JUMP_V0   = 12,
  parameter int unsigned MAX_FALL  = 15,
  parameter int unsigned ANIM_DIV  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        enable,
  input  logic [15:0] keycode,
  output logic [9:0]  samus_x,
  output logic [9:0]  samus_y,
  output logic        direction,
  output logic        walk,
  output logic        jump
);

  localparam logic [7:0]  KEY_LEFT  = 8'h04;
  localparam logic [7:0]  KEY_RIGHT = 8'h07;
  localparam logic [7:0]  KEY_JUMP  = 8'h1A;
  localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] STEP_W    = 11'(WALK_STEP);
  localparam logic [10:0] GROUND_W  = 11'(GROUND_Y);
  localparam logic [4:0]  JUMP_V0_W = 5'(JUMP_V0);
  localparam logic [4:0]  MAX_FALL_W = 5'(MAX_FALL);
  localparam int          ANIM_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  state_t              state_r;
  logic                vsync_d_r;
  logic [9:0]          x_r;
  logic [9:0]          y_r;
  logic [4:0]          vy_r;
  logic                direction_r;
  logic                walk_r;
  logic                jump_r;
  logic                armed_r;
  logic [ANIM_W-1:0]   anim_cnt_r;
`ifdef SAMUS_DOUBLE_JUMP_EN
  logic                dj_used_r;
`endif

  logic        tick_s, step_s;
  logic        left_key_s, right_key_s, jump_key_s;
  logic        go_left_s, go_right_s, moving_s;
  logic [10:0] x_ext_s;
  logic [9:0]  x_left_s, x_right_s;
  logic        ground_launch_s, air_launch_s, launch_s;
  logic [4:0]  rise_v_s, rise_vy_s, fall_vy_s;
  logic [9:0]  rise_y_s;
  logic        rise_done_s, land_s;
  logic [10:0] fall_sum_s;

  // Key decode, frame tick and next-value arithmetic for position/velocity
  always_comb begin
    tick_s      = vsync_d_r & ~vsync;
    step_s      = tick_s & enable;
    left_key_s  = (keycode[7:0] == KEY_LEFT)  | (keycode[15:8] == KEY_LEFT);
    right_key_s = (keycode[7:0] == KEY_RIGHT) | (keycode[15:8] == KEY_RIGHT);
    jump_key_s  = (keycode[7:0] == KEY_JUMP)  | (keycode[15:8] == KEY_JUMP);
    go_left_s   = left_key_s & ~right_key_s;
    go_right_s  = right_key_s & ~left_key_s;
    moving_s    = go_left_s | go_right_s;

    // 11-bit arithmetic so neither clamp can wrap
    x_ext_s = {1'b0, x_r};
    if (x_ext_s < (X_MIN_W + STEP_W)) begin
      x_left_s = X_MIN_W[9:0];
    end else begin
      x_left_s = 10'(x_ext_s - STEP_W);
    end
    if ((x_ext_s + STEP_W) > X_MAX_W) begin
      x_right_s = X_MAX_W[9:0];
    end else begin
      x_right_s = 10'(x_ext_s + STEP_W);
    end

    ground_launch_s = (state_r == ST_GROUND) & jump_key_s & armed_r;
`ifdef SAMUS_DOUBLE_JUMP_EN
    air_launch_s = (state_r != ST_GROUND) & jump_key_s & armed_r & ~dj_used_r;
`else
    air_launch_s = 1'b0;
`endif
    launch_s = ground_launch_s | air_launch_s;

    // A take-off frame is a rise step starting from the launch velocity
    if (launch_s) begin
      rise_v_s = JUMP_V0_W;
    end else begin
      rise_v_s = vy_r;
    end
    if (y_r < {5'b00000, rise_v_s}) begin
      rise_y_s = 10'd0;
    end else begin
      rise_y_s = y_r - {5'b00000, rise_v_s};
    end
    rise_vy_s   = rise_v_s - 5'd1;
    rise_done_s = (rise_vy_s == 5'd0) | (rise_y_s == 10'd0);

    if (vy_r >= MAX_FALL_W) begin
      fall_vy_s = MAX_FALL_W;
    end else begin
      fall_vy_s = vy_r + 5'd1;
    end
    fall_sum_s = {1'b0, y_r} + {6'b000000, fall_vy_s};
    land_s     = (fall_sum_s >= GROUND_W);
  end

  // Frame-rate motion state machine; all registers advance only on an enabled tick
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d_r   <= 1'b1;
      state_r     <= ST_GROUND;
      x_r         <= 10'(X_START);
      y_r         <= 10'(GROUND_Y);
      vy_r        <= 5'd0;
      direction_r <= 1'b0;
      walk_r      <= 1'b0;
      jump_r      <= 1'b0;
      armed_r     <= 1'b1;
      anim_cnt_r  <= '0;
`ifdef SAMUS_DOUBLE_JUMP_EN
      dj_used_r   <= 1'b0;
`endif
    end else begin
      vsync_d_r <= vsync;
      if (step_s) begin
        if (go_left_s) begin
          x_r         <= x_left_s;
          direction_r <= 1'b1;
        end else if (go_right_s) begin
          x_r         <= x_right_s;
          direction_r <= 1'b0;
        end else begin
          x_r         <= x_r;
          direction_r <= direction_r;
        end

        // Walk phase only animates on the floor; pre-tick state decides
        if (moving_s && (state_r == ST_GROUND)) begin
          if (anim_cnt_r == ANIM_LAST) begin
            anim_cnt_r <= '0;
            walk_r     <= ~walk_r;
          end else begin
            anim_cnt_r <= anim_cnt_r + ANIM_W'(1);
          end
        end else begin
          anim_cnt_r <= '0;
          walk_r     <= 1'b0;
        end

        // Re-arm requires a frame with W released, so a held key never re-triggers
        if (!jump_key_s) begin
          armed_r <= 1'b1;
        end else if (launch_s) begin
          armed_r <= 1'b0;
        end else begin
          armed_r <= armed_r;
        end

        if (launch_s || (state_r == ST_RISE)) begin
          y_r    <= rise_y_s;
          jump_r <= 1'b1;
          if (rise_done_s) begin
            state_r <= ST_FALL;
            vy_r    <= 5'd0;
          end else begin
            state_r <= ST_RISE;
            vy_r    <= rise_vy_s;
          end
        end else begin
          case (state_r)
            ST_FALL: begin
              if (land_s) begin
                y_r     <= 10'(GROUND_Y);
                vy_r    <= 5'd0;
                state_r <= ST_GROUND;
                jump_r  <= 1'b0;
              end else begin
                y_r     <= fall_sum_s[9:0];
                vy_r    <= fall_vy_s;
                jump_r  <= 1'b1;
              end
            end
            ST_GROUND: begin
              jump_r <= 1'b0;
            end
            default: begin
              state_r <= ST_GROUND;
              y_r     <= 10'(GROUND_Y);
              vy_r    <= 5'd0;
              jump_r  <= 1'b0;
            end
          endcase
        end

`ifdef SAMUS_DOUBLE_JUMP_EN
        if (air_launch_s) begin
          dj_used_r <= 1'b1;
        end else if ((state_r == ST_FALL) && land_s && !launch_s) begin
          dj_used_r <= 1'b0;
        end else begin
          dj_used_r <= dj_used_r;
        end
`endif
      end
    end
  end

  assign samus_x   = x_r;
  assign samus_y   = y_r;
  assign direction = direction_r;
  assign walk      = walk_r;
  assign jump      = jump_r;

endmodule

// File: tb/tb_samus_motion_ctrl.sv
// Self-checking bench for samus_motion_ctrl: a frame-level behavioural model
// (plain integer physics) is compared against the DUT on every falling clock
// edge, plus hand-computed literal checks for the documented scenarios.
module tb_samus_motion_ctrl;

`ifdef SAMUS_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic [9:0]  samus_x, samus_y;
  logic        direction, walk, jump;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // model state
  int m_x, m_y, m_vy, m_cnt;
  bit m_dir, m_walk, m_air, m_up, m_armed, m_dj;

  samus_motion_ctrl dut (
    .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .keycode(keycode),
    .samus_x(samus_x), .samus_y(samus_y), .direction(direction), .walk(walk), .jump(jump)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_x = 304; m_y = 400; m_vy = 0; m_cnt = 0;
    m_dir = 1'b0; m_walk = 1'b0; m_air = 1'b0; m_up = 1'b0; m_armed = 1'b1; m_dj = 1'b0;
  endtask

  // One enabled frame of game physics, written from the rules, not the RTL
  task automatic model_tick(input logic [15:0] key);
    bit l, r, w, launch;
    l = (key[7:0] == 8'h04) || (key[15:8] == 8'h04);
    r = (key[7:0] == 8'h07) || (key[15:8] == 8'h07);
    w = (key[7:0] == 8'h1A) || (key[15:8] == 8'h1A);
    if (l && !r) begin
      m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
      m_dir = 1'b1;
    end else if (r && !l) begin
      m_x = (m_x + 2 > 608) ? 608 : m_x + 2;
      m_dir = 1'b0;
    end
    if ((l ^ r) && !m_air) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 8) begin
        m_cnt = 0;
        m_walk = ~m_walk;
      end
    end else begin
      m_cnt = 0;
      m_walk = 1'b0;
    end
    launch = w && m_armed && (!m_air || (DJ && !m_dj));
    if (!w) m_armed = 1'b1;
    else if (launch) m_armed = 1'b0;
    if (launch) begin
      if (m_air) m_dj = 1'b1;
      m_air = 1'b1;
      m_up = 1'b1;
      m_vy = 12;
    end
    if (m_air && m_up) begin
      m_y = (m_y < m_vy) ? 0 : m_y - m_vy;
      m_vy = m_vy - 1;
      if (m_vy == 0 || m_y == 0) begin
        m_up = 1'b0;
        m_vy = 0;
      end
    end else if (m_air) begin
      m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
      if (m_y + m_vy >= 400) begin
        m_y = 400; m_vy = 0; m_air = 1'b0; m_dj = 1'b0;
      end else begin
        m_y = m_y + m_vy;
      end
    end
  endtask

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      n_checks = n_checks + 1;
      if (samus_x !== 10'(m_x) || samus_y !== 10'(m_y) || direction !== m_dir ||
          walk !== m_walk || jump !== m_air) begin
        n_fail = n_fail + 1;
        $display("FAIL cycle_cmp t=%0t got x=%0d y=%0d dir=%0b walk=%0b jump=%0b expected x=%0d y=%0d dir=%0b walk=%0b jump=%0b",
                 $time, samus_x, samus_y, direction, walk, jump, m_x, m_y, m_dir, m_walk, m_air);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One VGA frame: vsync falls (tick), stays low a little, rises again
  task automatic frame(input logic [15:0] key, input logic en);
    @(negedge clk);
    keycode = key;
    enable  = en;
    vsync   = 1'b0;
    @(posedge clk);
    if (en) model_tick(key);
    @(negedge clk);
    keycode = 16'($urandom);   // junk between ticks must be ignored
    repeat ($urandom_range(0, 2)) @(negedge clk);
    vsync = 1'b1;
    keycode = key;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [15:0] pick_key();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'h0004;
      2:       return 16'h0007;
      3:       return 16'h001A;
      4:       return 16'h0704;
      5:       return 16'h1A04;
      6:       return 16'h071A;
      7:       return 16'h1A00;
      8:       return 16'h0400;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // reset state
    do_reset();
    check_en = 1'b1;
    check_lit("reset_x", int'(samus_x), 304);
    check_lit("reset_y", int'(samus_y), 400);
    check_lit("reset_dir", int'(direction), 0);
    check_lit("reset_walk", int'(walk), 0);
    check_lit("reset_jump", int'(jump), 0);

    // walk right 10 frames
    for (int i = 1; i <= 10; i++) begin
      frame(16'h0007, 1'b1);
      if (i == 7) check_lit("walk_before_8", int'(walk), 0);
      if (i == 8) check_lit("walk_at_8", int'(walk), 1);
    end
    check_lit("right_x", int'(samus_x), 324);
    check_lit("right_dir", int'(direction), 0);

    // both keys held: hold, walk drops
    repeat (5) frame(16'h0704, 1'b1);
    check_lit("ad_x", int'(samus_x), 324);
    check_lit("ad_dir", int'(direction), 0);
    check_lit("ad_walk", int'(walk), 0);

    // frozen while disabled
    repeat (3) frame(16'h0007, 1'b0);
    check_lit("frozen_x", int'(samus_x), 324);
    check_lit("frozen_walk", int'(walk), 0);

    // walk left into the clamp
    repeat (200) frame(16'h0004, 1'b1);
    check_lit("left_x", int'(samus_x), 0);
    check_lit("left_dir", int'(direction), 1);

    // single jump with W held throughout
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      frame(16'h001A, 1'b1);
      if (i == 1) begin
        check_lit("jump_t1_y", int'(samus_y), 388);
        check_lit("jump_t1_air", int'(jump), 1);
      end
      if (i == 12) check_lit("jump_t12_y", int'(samus_y), 322);
      if (i == 24) begin
        check_lit("jump_t24_y", int'(samus_y), 400);
        check_lit("jump_t24_air", int'(jump), 0);
      end
    end
    check_lit("held_w_no_retake", int'(jump), 0);
    frame(16'h0000, 1'b1);
    frame(16'h001A, 1'b1);
    check_lit("retake_y", int'(samus_y), 388);

    // second press while airborne
    do_reset();
    frame(16'h001A, 1'b1);
    repeat (4) frame(16'h0000, 1'b1);
    frame(16'h001A, 1'b1);
    check_lit("second_press_y", int'(samus_y), DJ ? 338 : 343);
    repeat (40) frame(pick_key(), 1'b1);

    // randomized play with occasional resets and disabled frames
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else frame(pick_key(), ($urandom_range(0, 9) != 0));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
